// File: rtl/sram_wrapper_pkg.sv
// rtl/sram_wrapper_pkg.sv - shared state encoding and byte-merge helper for SRAM wrappers
package sram_wrapper_pkg;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_MERGE = 2'd2;

  typedef enum logic [1:0] {
    ST_INIT  = S_INIT,
    ST_IDLE  = S_IDLE,
    ST_MERGE = S_MERGE
  } state_e;

  // Upper bounds for the width-generic merge; callers cast in and out.
  localparam int unsigned MERGE_MAX_DW = 1024;
  localparam int unsigned MERGE_MAX_NB = 128;

  // Take new_word bytes where be is set, old_word bytes elsewhere.
  function automatic logic [MERGE_MAX_DW-1:0] byte_merge(
    input logic [MERGE_MAX_DW-1:0] old_word,
    input logic [MERGE_MAX_DW-1:0] new_word,
    input logic [MERGE_MAX_NB-1:0] be,
    input int unsigned             byte_width
  );
    logic [MERGE_MAX_DW-1:0] mask;
    logic [MERGE_MAX_DW-1:0] gran;
    logic [MERGE_MAX_NB-1:0] be_sh;
    mask  = '0;
    gran  = (MERGE_MAX_DW'(1) << byte_width) - MERGE_MAX_DW'(1);
    be_sh = be;
    for (int b = 0; b < int'(MERGE_MAX_NB); b++) begin
      if (be_sh[0]) mask = mask | (gran << (b * byte_width));
      be_sh = be_sh >> 1;
    end
    return (new_word & mask) | (old_word & ~mask);
  endfunction

endpackage

// File: rtl/sp_sram_param_wrapper_if.sv
// rtl/sp_sram_param_wrapper_if.sv - ready/valid request bus of the SRAM wrapper
interface sp_sram_param_wrapper_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NBYTES     = 4
);
  logic                  req;
  logic                  we;
  logic [NBYTES-1:0]     be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  init_done;

  modport master (
    output req, we, be, addr, wdata,
    input  ready, rvalid, rdata, init_done
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ready, rvalid, rdata, init_done
  );
endinterface

// File: rtl/fpga_universal_sp_sram_gen.sv
// rtl/fpga_universal_sp_sram_gen.sv - generic single-port SRAM macro with registered read
module fpga_universal_sp_sram_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  localparam int NB        = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [NB-1:0]         we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Per-lane write; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int g = 0; g < NB; g++) begin
      if (cs && we[g]) mem[addr][g*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[g*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Read port registers on a selected cycle with no lane written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (cs && (we == '0)) q <= mem[addr];
  end

endmodule

// File: rtl/sp_sram_param_wrapper.sv
// rtl/sp_sram_param_wrapper.sv - byte-enable SRAM wrapper with init fill and RMW partial writes
module sp_sram_param_wrapper
  import sram_wrapper_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   NBYTES     = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  sp_sram_param_wrapper_if.slave  bus
);

  state_e                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  ready_q;
  logic                  rvalid_q;
  logic                  init_done_q;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [NBYTES-1:0]     cap_be;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic                  m_cs;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_q;
  logic [DATA_WIDTH-1:0] merged;

  logic accept;
  logic be_full;
  logic be_any;

  assign accept  = bus.req && ready_q && (state == ST_IDLE);
  assign be_full = &bus.be;
  assign be_any  = |bus.be;

  // The macro q during MERGE is the old word fetched by the RMW read.
  assign merged = DATA_WIDTH'(byte_merge(MERGE_MAX_DW'(m_q), MERGE_MAX_DW'(cap_wdata),
                                         MERGE_MAX_NB'(cap_be), BYTE_WIDTH));

  // Macro control: fill writes in INIT, direct access in IDLE, merged write-back in MERGE.
  always_comb begin
    m_cs    = 1'b0;
    m_we    = 1'b0;
    m_addr  = bus.addr;
    m_wdata = bus.wdata;
    case (state)
      ST_INIT: begin
        m_cs    = 1'b1;
        m_we    = 1'b1;
        m_addr  = init_cnt;
        m_wdata = INIT_VALUE;
      end
      ST_IDLE: begin
        if (accept && (!bus.we || be_any)) begin
          m_cs = 1'b1;
          m_we = bus.we && be_full;
        end
      end
      ST_MERGE: begin
        m_cs    = 1'b1;
        m_we    = 1'b1;
        m_addr  = cap_addr;
        m_wdata = merged;
      end
      default: ;
    endcase
  end

  // Control FSM with registered ready/rvalid/init_done and RMW capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= INIT_EN ? ST_INIT : ST_IDLE;
      init_cnt    <= '0;
      ready_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      init_done_q <= 1'b0;
      cap_addr    <= '0;
      cap_be      <= '0;
      cap_wdata   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_cnt == '1) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          ready_q     <= 1'b1;
          init_done_q <= 1'b1;
          if (accept) begin
            if (!bus.we) begin
              rvalid_q <= 1'b1;
            end else if (be_any && !be_full) begin
              cap_addr  <= bus.addr;
              cap_be    <= bus.be;
              cap_wdata <= bus.wdata;
              ready_q   <= 1'b0;
              state     <= ST_MERGE;
            end
          end
        end
        ST_MERGE: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rvalid_q ? m_q : '0;
  assign bus.init_done = init_done_q;

  fpga_universal_sp_sram_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (~rstn),
    .cs    (m_cs),
    .we    (m_we),
    .addr  (m_addr),
    .wdata (m_wdata),
    .q     (m_q)
  );

endmodule

// File: doc/sp_sram_param_wrapper.md
# sp_sram_param_wrapper

Parametrised single-port SRAM wrapper that adds byte-granular writes, post-reset memory initialisation and a ready/valid request interface on top of the generic FPGA single-port macro. The macro is instantiated with whole-word writes only, so partial writes are handled inside the block by a read-modify-write sequence. The block sits between bus slave adapters (AHB/APB SRAM slaves) and the memory primitive. It is the common replacement for fixed-size SRAM wrappers.

## Interface
Parameters:
- ADDR_WIDTH, 8, word address width; depth = 2^ADDR_WIDTH words
- DATA_WIDTH, 32, word width in bits
- BYTE_WIDTH, 8, write-enable granule; DATA_WIDTH must be a multiple of it; NBYTES = DATA_WIDTH/BYTE_WIDTH
- INIT_EN, 1, 1 = fill the memory with INIT_VALUE after reset
- INIT_VALUE, 0, fill word, DATA_WIDTH bits

Ports:
- clk  in  1  clock; the block has a single clock
- rstn  in  1  reset, asynchronous assert, active-low
- req  in  1  request valid
- we  in  1  1 = write, 0 = read
- be  in  NBYTES  byte enables for writes; ignored on reads
- addr  in  ADDR_WIDTH  word address
- wdata  in  DATA_WIDTH  write data
- ready  out  1  request accepted when req & ready
- rvalid  out  1  read data valid pulse
- rdata  out  DATA_WIDTH  read data; 0 whenever rvalid = 0
- init_done  out  1  initialisation complete; stays high until the next reset

## Operation
- States: INIT, IDLE, MERGE.
- Reset: state = INIT if INIT_EN, otherwise IDLE. Output reset values: ready 0, rvalid 0, rdata 0, init_done 0.
- INIT:
  - Writes INIT_VALUE to addresses 0 .. 2^ADDR_WIDTH-1, one word per cycle, using an ADDR_WIDTH-bit counter.
  - After the last address is written, the block moves to IDLE and sets init_done. The counter does not wrap.
  - ready = 0 and req is ignored throughout.
- IDLE: ready = 1. On an accepted request:
  - Read: macro read issued in the same cycle.
  - Write, be all ones: full-word macro write in the same cycle. The block stays in IDLE.
  - Write, be = 0: accepted as a no-op. No macro access.
  - Write, partial be: macro read of addr issued. addr, be and wdata are captured. The block moves to MERGE.
- MERGE:
  - ready = 0.
  - Merged word = wdata bytes where be = 1, macro q bytes elsewhere.
  - The merged word is written to the captured addr. The block returns to IDLE.
- Without INIT_EN, init_done = 1 from the first clock edge after reset release.
- The merge read does not assert rvalid.
- Reset asserted mid-RMW or mid-INIT: the operation is abandoned. The target word content is undefined. INIT restarts when INIT_EN = 1.

## Timing
- Read latency: accepted in cycle N; rvalid = 1 with rdata in cycle N+1, for exactly one cycle. There is no backpressure on rvalid.
- Reads and full-word writes are fully pipelined: one accepted request per cycle.
- A partial write occupies 2 cycles: ready is low in cycle N+1. The next request is accepted in cycle N+2.
- Read-after-write to the same address:
  - Full write in N, read in N+1: returns new data in N+2.
  - Partial write in N, read in N+2: returns the merged data.
- A read accepted in N and a partial write accepted in N+1 are legal. rvalid for the read occurs in N+1, the same cycle the RMW read is issued.
- INIT duration: exactly 2^ADDR_WIDTH cycles after the first clock edge following reset release. init_done and ready rise in the same cycle.

## Structure
- Shared package sram_wrapper_pkg holds:
  - state encoding localparams (INIT, IDLE, MERGE)
  - a byte-merge function (old word, new word, be → merged word), reused by future dual-port wrappers
- One sub-module: fpga_universal_sp_sram_gen.
  - Instantiated with BYTE_WIDTH = DATA_WIDTH, so we = be on the single enable bit.
  - rst = ~rstn.
  - cs asserted only on cycles with a macro access.
- All control lives in this block: FSM, init counter, capture registers, rvalid register and merge mux.

## Test plan
- Reset release, INIT_EN=1, INIT_VALUE=32'hA5A5A5A5, ADDR_WIDTH=4 → ready/init_done low for 16 cycles, then high. Reads of addresses 0 and 15 return A5A5A5A5.
- Full write 0x3 ← 32'h11223344, then read 0x3 on the next cycle → rvalid the cycle after the read with rdata = 11223344. rdata = 0 in all other cycles.
- Word holds 11223344; partial write be=4'b0101, wdata=32'hAABBCCDD → ready low for 1 cycle. A subsequent read returns 11BB33DD.
- Back-to-back reads of 0,1,2,3 on consecutive cycles → four consecutive rvalid pulses, in order, with the correct data.
- Write with be=0 to a word holding 5 → no macro access (cs low); a read still returns 5.
- rstn asserted during MERGE → all outputs 0 immediately. After release, INIT reruns and the target word reads INIT_VALUE.
